// File: rtl/axi_byte_arbiter.sv
// Round-robin arbiter sharing one axi_byte_io engine between NUM_REQ requesters,
// with a watchdog that releases the requester if the engine never completes.
module axi_byte_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [32*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    resp_done,
   output logic [7:0]            resp_rdata,
   output logic                  resp_timeout,
   input  logic                  io_busy,
   output logic                  io_start,
   output logic [31:0]           io_addr,
   output logic                  io_write,
   output logic [7:0]            io_wdata,
   input  logic                  io_done,
   input  logic [7:0]            io_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = IDX_W + 1;
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]  WD_LAST   = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] last, owner, winner, cand;
   logic [SUM_W-1:0] sum;
   logic [WD_W-1:0]  wdog;
   logic             found, grant, wdog_expired;
   logic [31:0]      sel_addr;
   logic [7:0]       sel_wdata;
   logic             sel_write;

   // Search starts just after the previous owner, so the last winner ranks lowest.
   always_comb begin
      winner    = last;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[8*i +: 8];
            sel_write = req_write[i];
         end
      end
   end

   assign grant        = (state == IDLE) && found && !io_busy;
   assign wdog_expired = (TIMEOUT != 0) && (wdog == WD_LAST);

   // io_done takes precedence over the watchdog when both land on the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (grant) state_next = WAIT;
         WAIT: begin
            if (io_done)           state_next = IDLE;
            else if (wdog_expired) state_next = DRAIN;
         end
         DRAIN: if (io_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state        <= IDLE;
         req_ready    <= '0;
         resp_done    <= '0;
         resp_rdata   <= '0;
         resp_timeout <= 1'b0;
         io_start     <= 1'b0;
         io_addr      <= '0;
         io_write     <= 1'b0;
         io_wdata     <= '0;
         last         <= LAST_INIT;
         owner        <= '0;
         wdog         <= '0;
      end else begin
         state     <= state_next;
         req_ready <= '0;
         resp_done <= '0;
         io_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  io_addr   <= sel_addr;
                  io_write  <= sel_write;
                  io_wdata  <= sel_wdata;
                  req_ready <= NUM_REQ'(1) << winner;
                  io_start  <= 1'b1;
                  owner     <= winner;
                  wdog      <= '0;
               end
            end
            WAIT: begin
               wdog <= wdog + 1'b1;
               if (io_done) begin
                  resp_done    <= NUM_REQ'(1) << owner;
                  resp_rdata   <= io_rdata;
                  resp_timeout <= 1'b0;
                  last         <= owner;
               end else if (wdog_expired) begin
                  resp_done    <= NUM_REQ'(1) << owner;
                  resp_timeout <= 1'b1;
                  last         <= owner;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_byte_arbiter.sv
// Bench for axi_byte_arbiter: directed vector table, corner-case sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_axi_byte_arbiter;

   localparam int NR = 4;
   localparam int TO = 16;

   logic          aclk = 1'b0;
   logic          areset;
   logic [3:0]    req_valid, req_write, req_ready, resp_done;
   logic [127:0]  req_addr;
   logic [31:0]   req_wdata;
   logic [7:0]    resp_rdata, io_wdata, io_rdata;
   logic          resp_timeout, io_busy, io_start, io_write, io_done;
   logic [31:0]   io_addr;

   int total = 0;
   int bad   = 0;

   axi_byte_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
      .io_busy(io_busy), .io_start(io_start), .io_addr(io_addr), .io_write(io_write),
      .io_wdata(io_wdata), .io_done(io_done), .io_rdata(io_rdata)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]   valid;
      logic [3:0]   write;
      logic [127:0] addr;
      logic [31:0]  wdata;
      logic         busy;
      logic         done;
      logic [7:0]   rdata;
      logic [3:0]   e_ready;
      logic         e_start;
      logic [31:0]  e_addr;
      logic         e_write;
      logic [7:0]   e_wdata;
      logic [3:0]   e_done;
      logic [7:0]   e_rdata;
      logic         e_to;
   } vec_t;

   localparam logic [127:0] A1 = {32'h0, 32'h0, 32'h1003, 32'h0};
   localparam logic [127:0] A2 = {32'h0, 32'h2000, 32'h0, 32'h0};
   localparam logic [127:0] A3 = {32'h0, 32'h0, 32'h0, 32'h40};
   localparam logic [127:0] A4 = {32'h3003, 32'h0, 32'h3001, 32'h3000};
   localparam logic [127:0] RR_A = {32'h8003, 32'h8002, 32'h8001, 32'h8000};
   localparam logic [31:0]  W2 = 32'h00C3_0000;
   localparam logic [31:0]  W4 = 32'h1300_1110;

   task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] er, input logic es,
                              input logic [31:0] ea, input logic ew, input logic [7:0] ewd,
                              input logic [3:0] ed, input logic [7:0] erd, input logic eto,
                              input bit chk_rd);
      checkField({tag, ".req_ready"}, 32'(req_ready), 32'(er));
      checkField({tag, ".io_start"},  32'(io_start),  32'(es));
      checkField({tag, ".io_addr"},   io_addr,        ea);
      checkField({tag, ".io_write"},  32'(io_write),  32'(ew));
      checkField({tag, ".io_wdata"},  32'(io_wdata),  32'(ewd));
      checkField({tag, ".resp_done"}, 32'(resp_done), 32'(ed));
      if (chk_rd) checkField({tag, ".resp_rdata"}, 32'(resp_rdata), 32'(erd));
      if (ed != 4'b0) checkField({tag, ".resp_timeout"}, 32'(resp_timeout), 32'(eto));
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] w, input logic [127:0] a,
                                input logic [31:0] wd, input logic busy, input logic done,
                                input logic [7:0] rd);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = wd;
      io_busy   = busy;
      io_done   = done;
      io_rdata  = rd;
      @(posedge aclk);
      #1;
   endtask

   task automatic doReset();
      areset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      io_busy = 1'b0; io_done = 1'b0; io_rdata = '0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   function automatic int pick(input int last, input logic [3:0] v);
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (last + k) % NR;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   vec_t tbl[16];

   // Reference-model state for the random phase
   bit          m_owned, m_draining, rd_known, eng_pending;
   int          m_owner, m_last, m_grant_edge, eng_edge, edge_n;
   logic [31:0] ex_addr;
   logic        ex_write, ex_to;
   logic [7:0]  ex_wdata, ex_rdata;
   bit          pend[NR];
   logic        r_wr[NR];
   logic [31:0] r_addr[NR];
   logic [7:0]  r_wd[NR];

   initial begin
      tbl[0]  = '{4'b0010, 4'b0000, A1, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 32'h1003, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0};
      tbl[1]  = '{4'b0000, 4'b0000, A1, 32'h0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h1003, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0};
      tbl[2]  = '{4'b0000, 4'b0000, A1, 32'h0, 1'b1, 1'b1, 8'h5A, 4'b0000, 1'b0, 32'h1003, 1'b0, 8'h00, 4'b0010, 8'h5A, 1'b0};
      tbl[3]  = '{4'b0000, 4'b0000, A1, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h1003, 1'b0, 8'h00, 4'b0000, 8'h5A, 1'b0};
      tbl[4]  = '{4'b0100, 4'b0100, A2, W2,    1'b0, 1'b0, 8'h00, 4'b0100, 1'b1, 32'h2000, 1'b1, 8'hC3, 4'b0000, 8'h5A, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, A2, W2,    1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h2000, 1'b1, 8'hC3, 4'b0000, 8'h5A, 1'b0};
      tbl[6]  = '{4'b0000, 4'b0000, A2, W2,    1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h2000, 1'b1, 8'hC3, 4'b0000, 8'h5A, 1'b0};
      tbl[7]  = '{4'b0000, 4'b0000, A2, W2,    1'b1, 1'b1, 8'h5A, 4'b0000, 1'b0, 32'h2000, 1'b1, 8'hC3, 4'b0100, 8'h5A, 1'b0};
      tbl[8]  = '{4'b0001, 4'b0000, A3, 32'h0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h2000, 1'b1, 8'hC3, 4'b0000, 8'h5A, 1'b0};
      tbl[9]  = '{4'b0001, 4'b0000, A3, 32'h0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h2000, 1'b1, 8'hC3, 4'b0000, 8'h5A, 1'b0};
      tbl[10] = '{4'b0001, 4'b0000, A3, 32'h0, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b1, 32'h0040, 1'b0, 8'h00, 4'b0000, 8'h5A, 1'b0};
      tbl[11] = '{4'b0000, 4'b0000, A3, 32'h0, 1'b1, 1'b1, 8'hA5, 4'b0000, 1'b0, 32'h0040, 1'b0, 8'h00, 4'b0001, 8'hA5, 1'b0};
      tbl[12] = '{4'b1011, 4'b0000, A4, W4,    1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 32'h3001, 1'b0, 8'h11, 4'b0000, 8'hA5, 1'b0};
      tbl[13] = '{4'b0000, 4'b0000, A4, W4,    1'b1, 1'b1, 8'h11, 4'b0000, 1'b0, 32'h3001, 1'b0, 8'h11, 4'b0010, 8'h11, 1'b0};
      tbl[14] = '{4'b1001, 4'b0000, A4, W4,    1'b0, 1'b0, 8'h00, 4'b1000, 1'b1, 32'h3003, 1'b0, 8'h13, 4'b0000, 8'h11, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, A4, W4,    1'b1, 1'b1, 8'h22, 4'b0000, 1'b0, 32'h3003, 1'b0, 8'h13, 4'b1000, 8'h22, 1'b0};

      areset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      io_busy = 1'b0; io_done = 1'b0; io_rdata = '0;
      repeat (2) @(posedge aclk);
      #1;
      checkOutput("reset", 4'b0, 1'b0, 32'h0, 1'b0, 8'h0, 4'b0, 8'h0, 1'b0, 1'b1);
      checkField("reset.resp_timeout", 32'(resp_timeout), 32'h0);
      areset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i].valid, tbl[i].write, tbl[i].addr, tbl[i].wdata,
                       tbl[i].busy, tbl[i].done, tbl[i].rdata);
         checkOutput($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_start, tbl[i].e_addr,
                     tbl[i].e_write, tbl[i].e_wdata, tbl[i].e_done, tbl[i].e_rdata, tbl[i].e_to, 1'b1);
      end

      // Watchdog expiry, then a late completion that must be swallowed
      applyStimulus(4'b0001, 4'b0, {64'h0, 32'h6001, 32'h5000}, 32'h0, 1'b0, 1'b0, 8'h00);
      checkField("to.start", 32'(io_start), 32'h1);
      checkField("to.grant", 32'(req_ready), 32'h1);
      for (int k = 1; k <= 41; k++) begin
         applyStimulus((k >= 17) ? 4'b0010 : 4'b0000, 4'b0, {64'h0, 32'h6001, 32'h5000}, 32'h0,
                       1'b0, (k == 40), (k == 40) ? 8'hEE : 8'h00);
         if (k == 16) begin
            checkField("to.done", 32'(resp_done), 32'h1);
            checkField("to.flag", 32'(resp_timeout), 32'h1);
         end else if (k <= 40) begin
            checkField($sformatf("to.quiet%0d", k), 32'(resp_done), 32'h0);
         end
         if (k <= 40) checkField($sformatf("to.noready%0d", k), 32'(req_ready), 32'h0);
         else begin
            checkField("to.regrant", 32'(req_ready), 32'h2);
            checkField("to.readdr", io_addr, 32'h6001);
         end
      end
      applyStimulus(4'b0, 4'b0, '0, 32'h0, 1'b0, 1'b1, 8'h99);
      checkField("to.after.done", 32'(resp_done), 32'h2);
      checkField("to.after.rdata", 32'(resp_rdata), 32'h99);
      checkField("to.after.flag", 32'(resp_timeout), 32'h0);

      // io_done on the exact watchdog cycle counts as success
      applyStimulus(4'b0100, 4'b0, {32'h0, 32'h7002, 64'h0}, 32'h0, 1'b0, 1'b0, 8'h00);
      checkField("col.grant", 32'(req_ready), 32'h4);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(4'b0, 4'b0, '0, 32'h0, 1'b0, (k == 16), 8'h3C);
         if (k < 16) checkField($sformatf("col.quiet%0d", k), 32'(resp_done), 32'h0);
      end
      checkField("col.done", 32'(resp_done), 32'h4);
      checkField("col.flag", 32'(resp_timeout), 32'h0);
      checkField("col.rdata", 32'(resp_rdata), 32'h3C);
      applyStimulus(4'b0001, 4'b0, {96'h0, 32'h7000}, 32'h0, 1'b0, 1'b0, 8'h00);
      checkField("col.idle", 32'(req_ready), 32'h1);
      applyStimulus(4'b0, 4'b0, '0, 32'h0, 1'b0, 1'b1, 8'h6B);
      checkField("col.next.done", 32'(resp_done), 32'h1);

      // Asynchronous reset in the middle of an access
      applyStimulus(4'b1000, 4'b0, {32'h7777_0003, 96'h0}, {8'h5E, 24'h0}, 1'b0, 1'b0, 8'h00);
      checkField("arst.pre.start", 32'(io_start), 32'h1);
      checkField("arst.pre.ready", 32'(req_ready), 32'h8);
      req_valid = 4'b0;
      #2 areset = 1'b1;
      #1;
      checkOutput("arst", 4'b0, 1'b0, 32'h0, 1'b0, 8'h0, 4'b0, 8'h0, 1'b0, 1'b1);
      checkField("arst.resp_timeout", 32'(resp_timeout), 32'h0);
      @(posedge aclk);
      #1;
      areset = 1'b0;

      // All four requesting continuously: strict rotation starting at 0
      for (int n = 0; n < 5; n++) begin
         int waited;
         bit got;
         waited = 0;
         got = 1'b0;
         while (!got && waited < 8) begin
            applyStimulus(4'b1111, 4'b0, RR_A, 32'h0, 1'b0, 1'b0, 8'h00);
            waited++;
            if (io_start) got = 1'b1;
         end
         checkField($sformatf("rr%0d.granted", n), 32'(got), 32'h1);
         if (got) begin
            checkField($sformatf("rr%0d.ready", n), 32'(req_ready), 32'(1 << (n % NR)));
            checkField($sformatf("rr%0d.addr", n), io_addr, 32'h8000 + 32'(n % NR));
            applyStimulus(4'b1111, 4'b0, RR_A, 32'h0, 1'b0, 1'b0, 8'h00);
            applyStimulus(4'b1111, 4'b0, RR_A, 32'h0, 1'b0, 1'b1, 8'h40 + 8'(n));
            checkField($sformatf("rr%0d.done", n), 32'(resp_done), 32'(1 << (n % NR)));
            checkField($sformatf("rr%0d.rdata", n), 32'(resp_rdata), 32'h40 + 32'(n));
         end
      end

      // Randomized traffic against the transaction-level model
      doReset();
      m_owned = 0; m_draining = 0; rd_known = 1; eng_pending = 0;
      m_owner = 0; m_last = NR - 1; m_grant_edge = 0; eng_edge = 0; edge_n = 0;
      ex_addr = '0; ex_write = 1'b0; ex_wdata = '0; ex_rdata = '0; ex_to = 1'b0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 0; r_wr[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [3:0]   v, w, er, ed;
         logic [127:0] a;
         logic [31:0]  wd;
         logic         busy, done, es;
         logic [7:0]   rd;
         int           win;
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]   = 1;
               r_wr[i]   = 1'($urandom_range(0, 1));
               r_addr[i] = $urandom;
               r_wd[i]   = 8'($urandom);
            end
            v[i] = pend[i];
            w[i] = r_wr[i];
            a[32*i +: 32] = r_addr[i];
            wd[8*i +: 8]  = r_wd[i];
         end
         busy = ($urandom_range(0, 3) == 0);
         done = eng_pending && (edge_n + 1 == eng_edge);
         rd   = 8'($urandom);
         er = '0; ed = '0; es = 1'b0;
         if (m_owned) begin
            if (done) begin
               ed = 4'(1 << m_owner);
               ex_rdata = rd;
               rd_known = !ex_write;
               ex_to = 1'b0;
               m_last = m_owner;
               m_owned = 0;
            end else if (edge_n + 1 == m_grant_edge + TO) begin
               ed = 4'(1 << m_owner);
               ex_to = 1'b1;
               m_last = m_owner;
               m_owned = 0;
               m_draining = 1;
            end
         end else if (m_draining) begin
            if (done) m_draining = 0;
         end else if (v != 4'b0 && !busy) begin
            win = pick(m_last, v);
            er = 4'(1 << win);
            es = 1'b1;
            ex_addr = r_addr[win];
            ex_write = r_wr[win];
            ex_wdata = r_wd[win];
            m_owner = win;
            m_owned = 1;
            m_grant_edge = edge_n + 1;
         end
         applyStimulus(v, w, a, wd, busy, done, rd);
         edge_n++;
         checkOutput("rand", er, es, ex_addr, ex_write, ex_wdata, ed, ex_rdata, ex_to, rd_known);
         for (int i = 0; i < NR; i++) if (er[i]) pend[i] = 0;
         if (done) eng_pending = 0;
         if (es) begin
            eng_pending = 1;
            eng_edge = edge_n + $urandom_range(1, 22);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
